// File: rtl/dom_c_power_ctrl.sv
// Domain C power-gating sequencer.
// Orders clock, retention, isolation, reset and switch control around switch_ack.
`timescale 1ns/1ps
module dom_c_power_ctrl #(
  parameter int STEP_CYCLES   = 2,
  parameter int SETTLE_CYCLES = 8,
  parameter int ACK_TIMEOUT   = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic shutoff,
  input  logic test_mode,
  input  logic switch_ack,
  output logic c_clk_en,
  output logic dom_c_retain,
  output logic dom_c_isolate,
  output logic dom_c_pg_rst_n,
  output logic dom_c_switch_en,
  output logic powered_down,
  output logic busy,
  output logic pwr_err
);

  localparam int SW = $clog2(STEP_CYCLES + 1);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam int TW = $clog2(ACK_TIMEOUT + 1);

  localparam logic [SW-1:0] STEP_LAST = SW'(STEP_CYCLES - 1);
  localparam logic [CW-1:0] SET_LAST  = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(ACK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_RUN,
    S_CLK_OFF,
    S_SAVE,
    S_ISO,
    S_RST,
    S_PWR_OFF,
    S_OFF,
    S_PWR_ON,
    S_SETTLE,
    S_RST_REL,
    S_RESTORE,
    S_DE_ISO,
    S_CLK_ON
  } state_e;

  // {clk_en, retain, isolate, pg_rst_n, switch_en, powered_down, busy}
  localparam logic [6:0] RUN_V = 7'b1001100;

  state_e          state_q, state_d;
  logic [SW-1:0]   step_q, step_d;
  logic [CW-1:0]   set_q, set_d;
  logic [TW-1:0]   to_q, to_d;
  logic            err_q, err_d;
  logic [6:0]      out_q, out_d;
  logic            step_done;
  logic            to_done;

  assign step_done = (step_q >= STEP_LAST);
  assign to_done   = (to_q >= TO_LAST);

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    unique case (state_q)
      S_RUN:     if (shutoff) state_d = S_CLK_OFF;
      S_CLK_OFF: if (step_done) state_d = S_SAVE;
      S_SAVE:    if (step_done) state_d = S_ISO;
      S_ISO:     if (step_done) state_d = S_RST;
      S_RST:     if (step_done) state_d = S_PWR_OFF;
      S_PWR_OFF: begin
        if (!switch_ack) begin
          state_d = S_OFF;
        end else if (to_done) begin
          state_d = S_OFF;
          err_d   = 1'b1;
        end
      end
      S_OFF:     if (!shutoff) state_d = S_PWR_ON;
      S_PWR_ON: begin
        if (switch_ack) begin
          state_d = S_SETTLE;
        end else if (to_done) begin
          state_d = S_SETTLE;
          err_d   = 1'b1;
        end
      end
      S_SETTLE:  if (set_q >= SET_LAST) state_d = S_RST_REL;
      S_RST_REL: if (step_done) state_d = S_RESTORE;
      S_RESTORE: if (step_done) state_d = S_DE_ISO;
      S_DE_ISO:  if (step_done) state_d = S_CLK_ON;
      S_CLK_ON:  if (step_done) state_d = S_RUN;
      default:   state_d = S_RUN;
    endcase
  end

  // Counters restart on every state entry and stick at their limit.
  always_comb begin
    step_d = step_q;
    set_d  = set_q;
    to_d   = to_q;
    if (state_d != state_q) begin
      step_d = '0;
      set_d  = '0;
      to_d   = '0;
    end else begin
      if (!step_done)         step_d = step_q + SW'(1);
      if (set_q < SET_LAST)   set_d  = set_q + CW'(1);
      if (!to_done)           to_d   = to_q + TW'(1);
    end
  end

  always_comb begin
    out_d = RUN_V;
    unique case (state_q)
      S_RUN:     out_d = 7'b1001100;
      S_CLK_OFF: out_d = 7'b0001101;
      S_SAVE:    out_d = 7'b0101101;
      S_ISO:     out_d = 7'b0111101;
      S_RST:     out_d = 7'b0110101;
      S_PWR_OFF: out_d = 7'b0110001;
      S_OFF:     out_d = 7'b0110010;
      S_PWR_ON:  out_d = 7'b0110101;
      S_SETTLE:  out_d = 7'b0110101;
      S_RST_REL: out_d = 7'b0111101;
      S_RESTORE: out_d = 7'b0011101;
      S_DE_ISO:  out_d = 7'b0001101;
      S_CLK_ON:  out_d = 7'b1001101;
      default:   out_d = RUN_V;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      step_q  <= '0;
      set_q   <= '0;
      to_q    <= '0;
      err_q   <= 1'b0;
      out_q   <= RUN_V;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      set_q   <= set_d;
      to_q    <= to_d;
      err_q   <= err_d;
      out_q   <= out_d;
    end
  end

  logic [6:0] out_v;
  assign out_v = test_mode ? RUN_V : out_q;

  assign c_clk_en        = out_v[6];
  assign dom_c_retain    = out_v[5];
  assign dom_c_isolate   = out_v[4];
  assign dom_c_pg_rst_n  = out_v[3];
  assign dom_c_switch_en = out_v[2];
  assign powered_down    = out_v[1];
  assign busy            = out_v[0];
  assign pwr_err         = err_q;

endmodule

// File: tb/tb_dom_c_power_ctrl.sv
// Directed scoreboard bench for dom_c_power_ctrl.
// Expected output vectors are queued per cycle and popped at each falling edge.
`timescale 1ns/1ps
module tb_dom_c_power_ctrl;

  logic clk = 1'b0;
  logic rst, shutoff, test_mode, switch_ack;
  logic c_clk_en, dom_c_retain, dom_c_isolate, dom_c_pg_rst_n;
  logic dom_c_switch_en, powered_down, busy, pwr_err;

  dom_c_power_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .shutoff         (shutoff),
    .test_mode       (test_mode),
    .switch_ack      (switch_ack),
    .c_clk_en        (c_clk_en),
    .dom_c_retain    (dom_c_retain),
    .dom_c_isolate   (dom_c_isolate),
    .dom_c_pg_rst_n  (dom_c_pg_rst_n),
    .dom_c_switch_en (dom_c_switch_en),
    .powered_down    (powered_down),
    .busy            (busy),
    .pwr_err         (pwr_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // {clk_en, retain, isolate, pg_rst_n, switch_en, powered_down, busy}
  localparam logic [6:0] RUNV  = 7'b1001100;
  localparam logic [6:0] CKOFF = 7'b0001101;
  localparam logic [6:0] SAVEV = 7'b0101101;
  localparam logic [6:0] ISOV  = 7'b0111101;
  localparam logic [6:0] RSTV  = 7'b0110101;
  localparam logic [6:0] POFFV = 7'b0110001;
  localparam logic [6:0] OFFV  = 7'b0110010;
  localparam logic [6:0] PONV  = 7'b0110101;
  localparam logic [6:0] RRELV = 7'b0111101;
  localparam logic [6:0] RESTV = 7'b0011101;
  localparam logic [6:0] DISOV = 7'b0001101;
  localparam logic [6:0] CKONV = 7'b1001101;

  typedef struct {
    int         cyc;
    string      tag;
    logic [7:0] v;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  function automatic logic [7:0] obs();
    return {c_clk_en, dom_c_retain, dom_c_isolate, dom_c_pg_rst_n,
            dom_c_switch_en, powered_down, busy, pwr_err};
  endfunction

  task automatic cmp(input string tag, input logic [7:0] o,
                     input logic [7:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, o, e);
    end
  endtask

  task automatic pr(input int a, input int b, input string tag,
                    input logic [6:0] v, input logic err);
    exp_t x;
    for (int i = a; i <= b; i++) begin
      x.cyc = i;
      x.tag = tag;
      x.v   = {v, err};
      q.push_back(x);
    end
  endtask

  task automatic step();
    exp_t x;
    @(negedge clk);
    while (q.size() > 0 && q[0].cyc <= cyc) begin
      x = q.pop_front();
      cmp(x.tag, obs(), x.v);
    end
  endtask

  task automatic wait_to(input int c);
    while (cyc < c) step();
  endtask

  // Shutdown from RUN; tmo holds switch_ack high through PWR_OFF.
  task automatic shut(input logic err0, input bit pulse, input bit tmo,
                      output int e);
    e = cyc + 1;
    shutoff = 1'b1;
    pr(e,     e,     "run_pre", RUNV,  err0);
    pr(e + 1, e + 2, "clk_off", CKOFF, err0);
    pr(e + 3, e + 4, "save",    SAVEV, err0);
    pr(e + 5, e + 6, "iso",     ISOV,  err0);
    pr(e + 7, e + 8, "rst",     RSTV,  err0);
    if (!tmo) begin
      pr(e + 9, e + 10, "pwr_off", POFFV, err0);
      if (!pulse) pr(e + 11, e + 13, "off", OFFV, err0);
    end else begin
      pr(e + 9,  e + 39, "pwr_off_wait", POFFV, err0);
      pr(e + 40, e + 40, "tmo_err",      POFFV, 1'b1);
      pr(e + 41, e + 43, "off_tmo",      OFFV,  1'b1);
    end
    if (pulse) begin
      wait_to(e + 2);
      shutoff = 1'b0;
    end
    if (!tmo) begin
      wait_to(e + 9);
      switch_ack = 1'b0;
    end else begin
      wait_to(e + 41);
      switch_ack = 1'b0;
    end
    if (!pulse) wait_to(e + (tmo ? 43 : 13));
  endtask

  // Wake-up where OFF samples shutoff=0 at edge w; ack rises 3 cycles late.
  task automatic wake(input logic err, input int w);
    pr(w,      w,      "off_last", OFFV,  err);
    pr(w + 1,  w + 12, "pwr_on",   PONV,  err);
    pr(w + 13, w + 14, "rst_rel",  RRELV, err);
    pr(w + 15, w + 16, "restore",  RESTV, err);
    pr(w + 17, w + 18, "de_iso",   DISOV, err);
    pr(w + 19, w + 20, "clk_on",   CKONV, err);
    pr(w + 21, w + 23, "run",      RUNV,  err);
    wait_to(w + 3);
    switch_ack = 1'b1;
    wait_to(w + 23);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    rst = 1'b1;
    shutoff = 1'b0;
    test_mode = 1'b0;
    switch_ack = 1'b1;
    pr(1, 22, "reset_run", RUNV, 1'b0);
    wait_to(2);
    rst = 1'b0;
    wait_to(22);

    shut(1'b0, 1'b0, 1'b0, e);
    shutoff = 1'b0;
    wake(1'b0, cyc + 1);

    shut(1'b0, 1'b0, 1'b1, e);
    shutoff = 1'b0;
    wake(1'b1, cyc + 1);

    shut(1'b1, 1'b1, 1'b0, e);
    wake(1'b1, e + 11);

    shut(1'b1, 1'b0, 1'b0, e);
    test_mode = 1'b1;
    #1;
    cmp("tm_on", obs(), {RUNV, 1'b1});
    test_mode = 1'b0;
    #1;
    cmp("tm_off", obs(), {OFFV, 1'b1});
    shutoff = 1'b0;
    wake(1'b1, cyc + 1);

    e = cyc + 1;
    shutoff = 1'b1;
    pr(e,     e,     "run_pre2", RUNV,  1'b1);
    pr(e + 1, e + 2, "clk_off2", CKOFF, 1'b1);
    pr(e + 3, e + 3, "save2",    SAVEV, 1'b1);
    pr(e + 4, e + 6, "rst_abort", RUNV, 1'b0);
    wait_to(e + 3);
    rst = 1'b1;
    wait_to(e + 4);
    rst = 1'b0;
    shutoff = 1'b0;
    wait_to(e + 8);

    cmp("queue_empty", 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
